// File: rtl/denorm_mul_pkg.sv
// Shared definitions for the normalising divider / denormalising multiplier pair.
// Holds the state encoding and the default value/fraction widths.
package denorm_mul_pkg;

  localparam logic READY = 1'b0;
  localparam logic MULT  = 1'b1;

  localparam int S_DEF = 8;
  localparam int D_DEF = 8;

  typedef enum logic {
    ST_READY = READY,
    ST_MULT  = MULT
  } state_t;

endpackage

// File: rtl/denorm_mul_if.sv
// Start/ready bus of the denormalising multiplier; the master drives the request
// and the slave (the multiplier) returns the scaled value plus its FSM state.
interface denorm_mul_if #(
  parameter int S = denorm_mul_pkg::S_DEF,
  parameter int D = denorm_mul_pkg::D_DEF
) ();

  // Handshake: while en=1, a request is taken on the rising edge where
  // start=1 and ready=1; norm_i/max_i are captured on that edge only.
  // done pulses for one enabled cycle when result is updated; result holds
  // until the next completion. With en=0 everything, including done, holds.
  logic                  en;
  logic                  start;
  logic [D-1:0]          norm_i;
  logic [S+7:0]          max_i;
  logic [S+7:0]          result;
  logic                  ready;
  logic                  done;
  denorm_mul_pkg::state_t state;

  modport master (
    output en, start, norm_i, max_i,
    input  result, ready, done, state
  );

  modport slave (
    input  en, start, norm_i, max_i,
    output result, ready, done, state
  );

endinterface

// File: rtl/denorm_mul.sv
// Sequential shift-add multiplier: result = (norm_i * max_i) >> D, optionally
// rounded half-up, taking exactly D enabled cycles per operation.
module denorm_mul
  import denorm_mul_pkg::*;
#(
  parameter int S     = S_DEF,
  parameter int D     = D_DEF,
  parameter int ROUND = 1
) (
  input  logic         MHz10,
  input  logic         rst,
  denorm_mul_if.slave  bus
);

  localparam int W  = S + 8;
  localparam int AW = W + D + 1;
  localparam int IW = $clog2(D + 1);

  state_t          state, state_n;
  logic [AW-1:0]   acc, acc_n, acc_step;
  logic [D-1:0]    mplr, mplr_n;
  logic [W-1:0]    mcand, mcand_n;
  logic [IW-1:0]   i, i_n, i_dec;
  logic [W-1:0]    result, result_n, rounded;
  logic            done, done_n;

  always_comb begin
    state_n  = state;
    acc_n    = acc;
    mplr_n   = mplr;
    mcand_n  = mcand;
    i_n      = i;
    result_n = result;
    done_n   = 1'b0;

    // The multiplicand enters at bit D and the sum shifts right each step, so
    // after D steps acc holds the full product with D fraction bits below.
    acc_step = (acc + (mplr[0] ? {1'b0, mcand, {D{1'b0}}} : {AW{1'b0}})) >> 1;
    i_dec    = i - 1'b1;
    rounded  = acc_step[W+D-1:D] + ((ROUND != 0) ? W'(acc_step[D-1]) : {W{1'b0}});

    case (state)
      ST_READY: begin
        if (bus.start) begin
          acc_n   = '0;
          mplr_n  = bus.norm_i;
          mcand_n = bus.max_i;
          i_n     = IW'(D);
          state_n = ST_MULT;
        end
      end
      ST_MULT: begin
        acc_n  = acc_step;
        mplr_n = mplr >> 1;
        i_n    = i_dec;
        if (i_dec == '0) begin
          result_n = rounded;
          done_n   = 1'b1;
          state_n  = ST_READY;
        end
      end
      default: state_n = ST_READY;
    endcase
  end

  always_ff @(posedge MHz10 or posedge rst) begin
    if (rst) begin
      state  <= ST_READY;
      acc    <= '0;
      mplr   <= '0;
      mcand  <= '0;
      i      <= '0;
      result <= '0;
      done   <= 1'b0;
    end else if (bus.en) begin
      state  <= state_n;
      acc    <= acc_n;
      mplr   <= mplr_n;
      mcand  <= mcand_n;
      i      <= i_n;
      result <= result_n;
      done   <= done_n;
    end
  end

  assign bus.ready  = (state == ST_READY);
  assign bus.done   = done;
  assign bus.result = result;
  assign bus.state  = state;

endmodule

// File: tb/tb_denorm_mul.sv
// Bench for denorm_mul: rounding and truncating instances driven in lockstep,
// vector table plus stall, reset-abort and back-to-back sequences.
module tb_denorm_mul;

  localparam int S = 8;
  localparam int D = 8;
  localparam int W = S + 8;
  localparam int TMO = 60;

  // ---------------- clock / reset ----------------
  logic MHz10 = 1'b0;
  logic rst;
  always #5 MHz10 = ~MHz10;

  logic         en, start;
  logic [D-1:0] norm_i;
  logic [W-1:0] max_i;

  denorm_mul_if #(.S(S), .D(D)) if_r ();
  denorm_mul_if #(.S(S), .D(D)) if_t ();

  assign if_r.en = en;  assign if_r.start = start;
  assign if_r.norm_i = norm_i;  assign if_r.max_i = max_i;
  assign if_t.en = en;  assign if_t.start = start;
  assign if_t.norm_i = norm_i;  assign if_t.max_i = max_i;

  denorm_mul #(.S(S), .D(D), .ROUND(1)) dut_r (.MHz10(MHz10), .rst(rst), .bus(if_r.slave));
  denorm_mul #(.S(S), .D(D), .ROUND(0)) dut_t (.MHz10(MHz10), .rst(rst), .bus(if_t.slave));

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_r_q[$];
  logic [W-1:0] exp_t_q[$];
  logic en_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [D-1:0] n, input logic [W-1:0] m, input bit rnd);
    logic [W+D-1:0] p;
    p = W'(n) * m;
    p = {{D{1'b0}}, m} * {{W{1'b0}}, n};
    return p[W+D-1:D] + (rnd ? W'(p[D-1]) : W'(0));
  endfunction

  always @(posedge MHz10) en_seen <= en;

  // A done seen after an enabled edge is a fresh completion.
  always @(negedge MHz10) begin
    if (!rst && en_seen && if_r.done) begin
      if (exp_r_q.size() == 0) check("spurious_done_r", 1, 0);
      else check("result_round", if_r.result, exp_r_q.pop_front());
      if (exp_t_q.size() == 0) check("spurious_done_t", 1, 0);
      else check("result_trunc", if_t.result, exp_t_q.pop_front());
      check("done_lockstep", if_t.done, 1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge MHz10);
    #1;
  endtask

  task automatic push_exp(input logic [W-1:0] er, input logic [W-1:0] et);
    exp_r_q.push_back(er);
    exp_t_q.push_back(et);
  endtask

  // Issues one request and returns enabled edges from the accepting edge to done.
  task automatic run_op(input logic [D-1:0] n, input logic [W-1:0] m, output int lat);
    norm_i = n;
    max_i  = m;
    start  = 1'b1;
    step();
    start  = 1'b0;
    lat = 1;
    while (!if_r.done && lat < TMO) begin
      step();
      lat++;
    end
    if (lat >= TMO) check("timeout_run_op", lat, 0);
  endtask

  typedef struct {
    logic [D-1:0] norm;
    logic [W-1:0] max;
    logic [W-1:0] exp_r;
    logic [W-1:0] exp_t;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int lat;
    int n;
    int bad;

    vecs[0] = '{8'h80, 16'd200,   16'd100,   16'd100};
    vecs[1] = '{8'hFF, 16'hFFFF,  16'd65279, 16'd65279};
    vecs[2] = '{8'h01, 16'd384,   16'd2,     16'd1};
    vecs[3] = '{8'h40, 16'd1000,  16'd250,   16'd250};
    vecs[4] = '{8'hC0, 16'd400,   16'd300,   16'd300};
    vecs[5] = '{8'h00, 16'd1234,  16'd0,     16'd0};
    vecs[6] = '{8'hFF, 16'd0,     16'd0,     16'd0};
    vecs[7] = '{8'h80, 16'd1,     16'd1,     16'd0};
    vecs[8] = '{8'hFF, 16'hFFFF,  16'd65279, 16'd65279};

    rst = 1'b1; en = 1'b1; start = 1'b0; norm_i = '0; max_i = '0;
    #1;
    check("reset_ready", if_r.ready, 1);
    check("reset_done", if_r.done, 0);
    check("reset_result", if_r.result, 0);
    check("reset_result_t", if_t.result, 0);
    step(); step();
    rst = 1'b0;
    step();

    // Table vectors: fixed latency, single-cycle done, ready back high.
    for (int k = 0; k < 9; k++) begin
      push_exp(vecs[k].exp_r, vecs[k].exp_t);
      run_op(vecs[k].norm, vecs[k].max, lat);
      check("latency", lat, D + 1);
      check("ready_after_done", if_r.ready, 1);
      step();
      check("done_one_cycle", if_r.done, 0);
    end

    // Random operands checked against the arithmetic model.
    for (int k = 0; k < 12; k++) begin
      logic [D-1:0] rn;
      logic [W-1:0] rm;
      rn = D'($urandom_range(0, (1 << D) - 1));
      rm = W'($urandom_range(0, (1 << W) - 1));
      push_exp(model(rn, rm, 1'b1), model(rn, rm, 1'b0));
      run_op(rn, rm, lat);
      check("latency_rand", lat, D + 1);
    end

    // Stall: en low for 3 cycles mid-operation; inputs changed while busy.
    push_exp(16'd250, 16'd250);
    norm_i = 8'h40; max_i = 16'd1000; start = 1'b1;
    step();
    start = 1'b0; n = 1;
    step(); step(); n = 3;
    norm_i = 8'hFF; max_i = 16'hFFFF;
    en = 1'b0;
    step(); step(); step(); n = 6;
    check("stall_not_done", if_r.done, 0);
    check("stall_busy", if_r.ready, 0);
    en = 1'b1;
    while (!if_r.done && n < TMO) begin step(); n++; end
    check("stall_latency", n, D + 1 + 3);
    en = 1'b0;
    step(); step();
    check("done_held_en_low", if_r.done, 1);
    check("result_held_en_low", if_r.result, 250);
    en = 1'b1;
    step();
    check("done_clears", if_r.done, 0);

    // Reset in cycle 4 of MULT aborts with no done pulse.
    norm_i = 8'h80; max_i = 16'd200; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    #1;
    check("abort_ready", if_r.ready, 1);
    check("abort_result", if_r.result, 0);
    check("abort_done", if_r.done, 0);
    step();
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (if_r.done || if_t.done) bad++;
    end
    check("abort_no_done", bad, 0);
    push_exp(16'd300, 16'd300);
    run_op(8'hC0, 16'd400, lat);
    check("after_abort_latency", lat, D + 1);
    step();

    // start held through MULT: ignored; second op accepted in the done cycle.
    push_exp(16'd100, 16'd100);
    norm_i = 8'h80; max_i = 16'd200; start = 1'b1;
    step();
    n = 1;
    norm_i = 8'h01; max_i = 16'd384;
    push_exp(16'd2, 16'd1);
    while (!if_r.done && n < TMO) begin
      if (n > 1) check("busy_while_start", if_r.ready, 0);
      step(); n++;
    end
    check("held_start_latency", n, D + 1);
    step();
    start = 1'b0;
    check("b2b_accepted", if_r.ready, 0);
    check("b2b_done_clear", if_r.done, 0);
    n = 1;
    while (!if_r.done && n < TMO) begin step(); n++; end
    check("b2b_latency", n, D + 1);
    step(); step();

    check("queue_empty_r", exp_r_q.size(), 0);
    check("queue_empty_t", exp_t_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=timeout expected=finish");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/denorm_mul.md
Name: denorm_mul

Overview:
- Sequential shift-add multiplier that scales a D-bit unsigned fraction (Q0.D) by a full-width maximum value.
- Computes result = (norm_i * max_i) >> D, with optional round-half-up.
- It is the inverse direction of the normalising divider: it converts normalised counts back into absolute units before they go to the display/PWM path.
- Same clock enable and start/ready style as the divider, so the two chain directly.

Parameters:
- S, 8, extra width of the value path; data width is S+8.
- D, 8, width of the fraction input and the number of multiply iterations.
- ROUND, 1, 1 = add product bit D-1 to the truncated result; 0 = truncate.

Ports:
- MHz10  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous active-high reset.
- en  input  1  clock enable; when low, all state, including done, holds.
- start  input  1  request; sampled only in READY with en=1.
- norm_i  input  D  unsigned fraction, value norm_i/2^D.
- max_i  input  S+8  unsigned full-scale multiplicand.
- result  output  S+8  registered scaled value; holds until next completion.
- ready  output  1  combinational, high when state==READY.
- done  output  1  registered one-enabled-cycle pulse on completion.

Behaviour:
- Reset (async, rst=1): state=READY, result=0, done=0, accumulator/multiplier/multiplicand/counter=0; ready=1 immediately.
- Internal registers:
  - acc, width S+8+D+1 (one carry bit).
  - mplr, width D.
  - mcand, width S+8.
  - i, width clog2(D+1).
- READY state:
  - en=1 and start=1: acc<=0, mplr<=norm_i, mcand<=max_i, i<=D, go to MULT.
  - done is cleared on any enabled cycle in which no completion occurs.
- MULT state, each en=1 cycle:
  - acc_next = (acc + (mplr[0] ? mcand<<D : 0)) >> 1.
  - mplr <= mplr>>1.
  - i <= i-1.
- Completion:
  - On the MULT cycle where i-1==0: result <= acc_next[S+7+D:D] + (ROUND ? acc_next[D-1] : 0), done<=1, state<=READY.
  - Exactly D enabled cycles in MULT; done is seen D+1 enabled cycles after the start cycle.
- Width rule: product < max_i*2^D, so the truncated result is always < max_i. After rounding, result is at most max_i. No overflow, no saturation needed.
- start while in MULT: ignored; ready=0, no restart.
- en low mid-operation: everything freezes, including done and the counter; resumes without loss.
- norm_i=0: result=0 after the full D cycles; no early exit, so latency is fixed.
- max_i=0: result=0.
- Inputs are captured at start; changes to norm_i/max_i during MULT have no effect.
- Reset mid-operation: aborts, all values return to reset values, no done pulse.
- Back-to-back: start may be asserted in the same cycle done is high (state is READY) and is accepted.

Decomposition:
- Shared package (with the divider): state encoding localparams READY=0, MULT=1, and default widths S=8, D=8.
- Single module. No sub-module; the add/shift datapath is one always_comb step.

Test Plan:
- norm_i=0x80, max_i=200, start one cycle, en=1 -> done after 9 cycles, result=100, ready back high.
- norm_i=0xFF, max_i=0xFFFF -> result=65279 (16711425>>8, round bit 0) for both ROUND values.
- norm_i=0x01, max_i=384 -> ROUND=1 gives result=2; ROUND=0 gives result=1.
- en toggled low for 3 cycles mid-MULT with norm_i=0x40, max_i=1000 -> result=250, done after 12 cycles total, done held while en=0.
- rst pulsed in cycle 4 of MULT -> result=0, done never pulses, ready=1 immediately. Subsequent start with norm_i=0xC0, max_i=400 -> result=300.
- start re-asserted every cycle during MULT -> ignored, single done. Second op accepted in the done cycle returns its own correct result.
